// File: rtl/sirv_pmu_pkg.sv
// Shared types and constants for the PMU key-unlock path.
// Holds the key FSM state encoding, the default magic key and a counter-width helper.
package sirv_pmu_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } pmu_key_state_e;

    localparam logic [31:0] PMU_KEY_DEFAULT = 32'h0051_F15E;

    // Width needed to hold values 0..depth-1; never narrower than one bit.
    function automatic int pmu_cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sirv_pmu_down_counter.sv
// Loadable saturating down counter with a zero flag.
// Used for the lockout timer and, when enabled, the unlock window timer.
module sirv_pmu_down_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Load wins over decrement; decrement stops at zero so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sirv_pmu_key_unlock.sv
// One-shot key unlock with brute-force lockout for protected PMU register writes.
// Optional unlock expiry is compiled in with `define SIRV_PMU_UNLOCK_TIMEOUT_EN.
module sirv_pmu_key_unlock
    import sirv_pmu_pkg::*;
#(
    parameter logic [31:0] KEY_VALUE      = PMU_KEY_DEFAULT,
    parameter int          MAX_FAILS      = 4,
    parameter int          LOCKOUT_CYCLES = 256
`ifdef SIRV_PMU_UNLOCK_TIMEOUT_EN
    ,
    parameter int          UNLOCK_WINDOW  = 64
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_key_write_valid,
    input  logic [31:0] io_key_write_bits,
    input  logic        io_prot_write_valid,
    output logic        unlocked,
    output logic [31:0] io_key_read,
    output logic        io_violation,
    output logic        io_lockout
);

    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int LOCK_W = pmu_cnt_width(LOCKOUT_CYCLES);

    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

    pmu_key_state_e    state_q;
    pmu_key_state_e    state_d;
    logic [FAIL_W-1:0] fail_q;
    logic [FAIL_W-1:0] fail_d;
    logic              unlocked_q;
    logic              violation_q;
    logic              lockout_q;

    logic key_ok;
    logic key_bad;
    logic lock_load;
    logic lock_dec;
    logic lock_zero;
    logic win_expired;

    assign key_ok  = io_key_write_valid && (io_key_write_bits == KEY_VALUE);
    assign key_bad = io_key_write_valid && (io_key_write_bits != KEY_VALUE);

    sirv_pmu_down_counter #(
        .WIDTH(LOCK_W)
    ) u_lock_cnt (
        .clock_i   (clock),
        .reset_i   (reset),
        .load_i    (lock_load),
        .load_val_i(LOCK_LOAD),
        .dec_i     (lock_dec),
        .zero_o    (lock_zero)
    );

`ifdef SIRV_PMU_UNLOCK_TIMEOUT_EN
    localparam int WIN_W = pmu_cnt_width(UNLOCK_WINDOW);
    localparam logic [WIN_W-1:0] WIN_LOAD = WIN_W'(UNLOCK_WINDOW - 1);

    logic win_load;
    logic win_dec;
    logic win_zero;

    // Every entry into UNLOCKED and every correct re-key restarts the window.
    assign win_load    = (state_d == UNLOCKED) && ((state_q != UNLOCKED) || key_ok);
    assign win_dec     = (state_q == UNLOCKED);
    assign win_expired = win_zero;

    sirv_pmu_down_counter #(
        .WIDTH(WIN_W)
    ) u_win_cnt (
        .clock_i   (clock),
        .reset_i   (reset),
        .load_i    (win_load),
        .load_val_i(WIN_LOAD),
        .dec_i     (win_dec),
        .zero_o    (win_zero)
    );
`else
    assign win_expired = 1'b0;
`endif

    // Key FSM: key writes take priority over protected-write consumption and expiry.
    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        lock_load = 1'b0;
        lock_dec  = 1'b0;
        unique case (state_q)
            LOCKED: begin
                if (key_ok) begin
                    state_d = UNLOCKED;
                    fail_d  = '0;
                end else if (key_bad) begin
                    if (fail_q >= FAIL_LAST) begin
                        state_d   = LOCKOUT;
                        lock_load = 1'b1;
                        fail_d    = '0;
                    end else begin
                        fail_d = fail_q + FAIL_W'(1);
                    end
                end
            end
            UNLOCKED: begin
                if (key_ok) begin
                    state_d = UNLOCKED;
                end else if (key_bad) begin
                    state_d = LOCKED;
                    fail_d  = FAIL_W'(1);
                end else if (io_prot_write_valid || win_expired) begin
                    state_d = LOCKED;
                end
            end
            LOCKOUT: begin
                fail_d = '0;
                if (lock_zero) begin
                    state_d = LOCKED;
                end else begin
                    lock_dec = 1'b1;
                end
            end
            default: begin
                state_d = LOCKED;
                fail_d  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they track the FSM one edge later.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= LOCKED;
            fail_q      <= '0;
            unlocked_q  <= 1'b0;
            violation_q <= 1'b0;
            lockout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            fail_q      <= fail_d;
            unlocked_q  <= (state_d == UNLOCKED);
            violation_q <= io_prot_write_valid && (state_q != UNLOCKED);
            lockout_q   <= (state_d == LOCKOUT);
        end
    end

    assign unlocked     = unlocked_q;
    assign io_key_read  = {31'b0, unlocked_q};
    assign io_violation = violation_q;
    assign io_lockout   = lockout_q;

endmodule

// File: tb/tb_sirv_pmu_key_unlock.sv
// Scoreboard bench for sirv_pmu_key_unlock: stimulus pushes per-cycle expectations,
// a monitor pops and compares them a little after each rising edge.
module tb_sirv_pmu_key_unlock;

    localparam logic [31:0] KEY = 32'h0051_F15E;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        keyValid = 1'b0;
    logic [31:0] keyBits = 32'h0;
    logic        protValid = 1'b0;
    logic        unlocked;
    logic [31:0] keyRead;
    logic        violation;
    logic        lockout;

    int checkCount = 0;
    int errorCount = 0;

    typedef struct packed {
        logic unl;
        logic viol;
        logic lock;
    } exp_t;

    exp_t  expQ[$];
    string nameQ[$];

    always #5 clock = ~clock;

    sirv_pmu_key_unlock dut (
        .clock              (clock),
        .reset              (reset),
        .io_key_write_valid (keyValid),
        .io_key_write_bits  (keyBits),
        .io_prot_write_valid(protValid),
        .unlocked           (unlocked),
        .io_key_read        (keyRead),
        .io_violation       (violation),
        .io_lockout         (lockout)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checkCount++;
        if (got !== want) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic kValid, input logic [31:0] kBits,
                                 input logic pValid, input logic eUnl, input logic eViol,
                                 input logic eLock, input string name);
        exp_t e;
        @(negedge clock);
        reset     = rst;
        keyValid  = kValid;
        keyBits   = kBits;
        protValid = pValid;
        e.unl  = eUnl;
        e.viol = eViol;
        e.lock = eLock;
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    task automatic idle(input logic eUnl, input logic eViol, input logic eLock, input string name);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, eUnl, eViol, eLock, name);
    endtask

    // Monitor: compares each queued expectation against the registered outputs.
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(posedge clock);
            #2;
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                checkOutput({n, ".unlocked"}, {31'b0, unlocked}, {31'b0, e.unl});
                checkOutput({n, ".key_read"}, keyRead, e.unl ? 32'h1 : 32'h0);
                checkOutput({n, ".violation"}, {31'b0, violation}, {31'b0, e.viol});
                checkOutput({n, ".lockout"}, {31'b0, lockout}, {31'b0, e.lock});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset, then a protected write while locked
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "reset0");
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "reset1");
        idle(1'b0, 1'b0, 1'b0, "post_reset");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, "locked_prot");
        idle(1'b0, 1'b0, 1'b0, "viol_one_cycle");

        // One-shot unlock consumed by a protected write
        applyStimulus(1'b0, 1'b1, KEY, 1'b0, 1'b1, 1'b0, 1'b0, "good_key");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, "consume");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, "second_prot");
        idle(1'b0, 1'b0, 1'b0, "after_second");

        // Four bad keys trigger a 256-cycle lockout
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "bad1");
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "bad2");
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "bad3");
        applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "bad4_lockout");
        for (int i = 1; i <= 255; i++) begin
            applyStimulus(1'b0, (i == 10), KEY, (i == 20), 1'b0, (i == 20), 1'b1,
                          $sformatf("lockout%0d", i));
        end
        idle(1'b0, 1'b0, 1'b0, "lockout_exit");
        applyStimulus(1'b0, 1'b1, KEY, 1'b0, 1'b1, 1'b0, 1'b0, "key_after_lockout");

        // Bad key with a protected write in the same cycle leaves fail count at one
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, "bad_with_prot");
        applyStimulus(1'b0, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, "fail_to_2");
        applyStimulus(1'b0, 1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, "fail_to_3");
        applyStimulus(1'b0, 1'b1, 32'h3, 1'b0, 1'b0, 1'b0, 1'b1, "fail_lockout");
        for (int i = 1; i <= 155; i++) begin
            idle(1'b0, 1'b0, 1'b1, $sformatf("partial_lockout%0d", i));
        end

        // Asynchronous reset part way through lockout
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async_reset.lockout", {31'b0, lockout}, 32'h0);
        checkOutput("async_reset.unlocked", {31'b0, unlocked}, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, "reset_hold");
        idle(1'b0, 1'b0, 1'b0, "reset_release");
        applyStimulus(1'b0, 1'b1, KEY, 1'b0, 1'b1, 1'b0, 1'b0, "key_after_reset");

        // Re-arm with a correct key alongside a protected write
        applyStimulus(1'b0, 1'b1, KEY, 1'b1, 1'b1, 1'b0, 1'b0, "rearm_with_prot");
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, "consume_rearm");

`ifdef SIRV_PMU_UNLOCK_TIMEOUT_EN
        applyStimulus(1'b0, 1'b1, KEY, 1'b0, 1'b1, 1'b0, 1'b0, "win_key");
        for (int i = 1; i <= 64; i++) begin
            idle((i < 64), 1'b0, 1'b0, $sformatf("win_idle%0d", i));
        end
        applyStimulus(1'b0, 1'b1, KEY, 1'b0, 1'b1, 1'b0, 1'b0, "win_key2");
        for (int i = 1; i <= 104; i++) begin
            applyStimulus(1'b0, (i == 40), KEY, 1'b0, (i < 104), 1'b0, 1'b0,
                          $sformatf("win_rearm%0d", i));
        end
`else
        applyStimulus(1'b0, 1'b1, KEY, 1'b0, 1'b1, 1'b0, 1'b0, "persist_key");
        for (int i = 1; i <= 100; i++) begin
            idle(1'b1, 1'b0, 1'b0, $sformatf("persist%0d", i));
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, "persist_consume");
`endif
        idle(1'b0, 1'b0, 1'b0, "final_idle");

        for (int i = 0; i < 4 && expQ.size() != 0; i++) begin
            @(posedge clock);
        end
        #3;
        if (expQ.size() != 0) begin
            errorCount++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/sirv_pmu_key_unlock.md
Name: sirv_pmu_key_unlock

Overview:
- Upstream stage of the PMU core register-write path; produces the `unlocked` qualifier that gates every protected PMU register write (e.g. the IE write strobe).
- Implements the one-shot key mechanism: a write of the magic key to the PMU key register arms exactly one protected write, after which the block relocks.
- Adds brute-force lockout after repeated bad keys. No debug or test bypass exists; `unlocked` is derived only from the key FSM.

Parameters:
- KEY_VALUE, 32'h0051_F15E, magic unlock key.
- MAX_FAILS, 4, consecutive bad key writes that trigger lockout (≥1).
- LOCKOUT_CYCLES, 256, cycles spent in LOCKOUT (≥1).
- UNLOCK_WINDOW, 64, cycles before an unused unlock expires (only with the optional feature).

Ports:
- clock  in  1  PMU clock.
- reset  in  1  asynchronous, active-high reset.
- io_key_write_valid  in  1  write strobe to the key register.
- io_key_write_bits  in  32  key write data.
- io_prot_write_valid  in  1  OR of all protected-register write strobes this cycle.
- unlocked  out  1  registered; high only in UNLOCKED state.
- io_key_read  out  32  key register read value: 32'h1 when unlocked, else 32'h0.
- io_violation  out  1  registered one-cycle pulse: protected write attempted while not unlocked.
- io_lockout  out  1  registered; high in LOCKOUT state.

Behaviour:
- Reset (async assert, sync use after deassert):
  - state = LOCKED, fail_cnt = 0, lock_cnt = 0.
  - unlocked = 0, io_violation = 0, io_lockout = 0.
- All outputs are registered and change one cycle after the causing edge.
- The consumer computes write_en = io_prot_write_valid & unlocked in the same cycle.
- State LOCKED:
  - Key write with data == KEY_VALUE -> UNLOCKED; fail_cnt = 0.
  - Key write with any other data -> fail_cnt += 1.
    - If fail_cnt + 1 == MAX_FAILS -> LOCKOUT; lock_cnt = LOCKOUT_CYCLES-1; fail_cnt = 0.
  - Protected write -> io_violation pulses next cycle; state unchanged.
- State UNLOCKED:
  - Protected write without a key write -> LOCKED (the unlock is consumed). The write itself is permitted because `unlocked` is still 1 in that cycle.
  - Key write with the correct key (with or without a protected write) -> remain UNLOCKED (re-arm).
  - Key write with a bad key -> LOCKED; fail_cnt = 1. Any protected write in that same cycle is still permitted.
- State LOCKOUT:
  - All key writes are ignored, including the correct key; fail_cnt is held at 0.
  - lock_cnt decrements each cycle; at 0 -> LOCKED.
  - Protected write -> io_violation pulse.
- Counter widths: fail_cnt is $clog2(MAX_FAILS+1) bits; lock_cnt is $clog2(LOCKOUT_CYCLES) bits, minimum 1. Neither counter wraps.
- Reset asserted in any state returns the block to LOCKED immediately; a partially counted lockout is discarded.

Optional Feature:
- Macro: SIRV_PMU_UNLOCK_TIMEOUT_EN.
- Defined:
  - Entering or re-arming UNLOCKED loads win_cnt = UNLOCK_WINDOW-1.
  - win_cnt decrements each cycle in UNLOCKED.
  - At win_cnt == 0 with no protected write and no correct key write -> LOCKED.
  - A protected write at win_cnt == 0 is still permitted.
- Undefined: no win_cnt; an unlock persists until consumed.

Decomposition:
- Shared package sirv_pmu_pkg:
  - pmu_key_state_e enum {LOCKED, UNLOCKED, LOCKOUT}.
  - PMU_KEY_DEFAULT constant.
- Sub-module sirv_pmu_down_counter (load / decrement / zero flag), instantiated for lock_cnt and, when enabled, win_cnt.

Test Plan:
- Reset, then a protected write -> unlocked=0; io_violation=1 for exactly one cycle; io_key_read=0.
- Key write 32'h0051F15E, then a protected write -> unlocked=1 during the write; unlocked=0 the cycle after; a second protected write -> io_violation=1.
- Four key writes of 32'h0 -> io_lockout=1 for 256 cycles; the correct key written during lockout has no effect; after 256 cycles, the correct key unlocks.
- Unlocked, then a bad key write together with a protected write in the same cycle -> write permitted; next state LOCKED; fail_cnt=1.
- Reset asserted mid-lockout (lock_cnt=100) -> io_lockout=0 immediately; the correct key then unlocks.
- With SIRV_PMU_UNLOCK_TIMEOUT_EN: correct key, idle 64 cycles -> unlocked drops to 0; correct key re-written at cycle 40 -> window reloads, and unlocked holds through cycle 103.
